// File: rtl/systolic_pe_pipelined_if.sv
// Bus bundle for one systolic PE: operand/tag inputs from the west/north neighbours and the drain
// controller, plus passthrough, result and status outputs.
//   master : drives north_i/west_i/valid_i/first_i/last_i/drain_mode_i/acc_read_i
//   slave  : the PE; drives south_o/east_o/valid_o/acc_o/acc_valid_o/done_o/busy_o/overflow_o
interface systolic_pe_pipelined_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40
);
  logic [DATA_WIDTH-1:0] north_i;
  logic [DATA_WIDTH-1:0] west_i;
  logic                  valid_i;
  logic                  first_i;
  logic                  last_i;
  logic                  drain_mode_i;
  logic                  acc_read_i;

  logic [DATA_WIDTH-1:0] south_o;
  logic [DATA_WIDTH-1:0] east_o;
  logic                  valid_o;
  logic [ACC_WIDTH-1:0]  acc_o;
  logic                  acc_valid_o;
  logic                  done_o;
  logic                  busy_o;
  logic                  overflow_o;

  modport master (
    output north_i, west_i, valid_i, first_i, last_i, drain_mode_i, acc_read_i,
    input  south_o, east_o, valid_o, acc_o, acc_valid_o, done_o, busy_o, overflow_o
  );

  modport slave (
    input  north_i, west_i, valid_i, first_i, last_i, drain_mode_i, acc_read_i,
    output south_o, east_o, valid_o, acc_o, acc_valid_o, done_o, busy_o, overflow_o
  );
endinterface

// File: rtl/systolic_pe_pipelined.sv
// Output-stationary systolic PE with a fully pipelined multiply-accumulate.
// Operands hop north->south and west->east with one register of latency every cycle. MAC beats
// flow through MUL_STAGES product registers and one accumulate stage; the final sum is held
// until the drain controller reads it.
// Ports:
//   clk_i   clock
//   rstn_i  asynchronous active-low reset
//   pe      systolic_pe_pipelined_if.slave (operands, tags, read request; passthrough, result,
//           done/busy/overflow status)
module systolic_pe_pipelined #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned MUL_STAGES = 2,
  parameter bit          SIGNED     = 1'b1,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  systolic_pe_pipelined_if.slave pe
);
  localparam int unsigned PW = 2 * DATA_WIDTH;
  // Extension width taking the product up to ACC_WIDTH+1 bits (one guard bit for overflow).
  localparam int unsigned XW = ACC_WIDTH - PW + 1;

  typedef enum logic [1:0] {StIdle, StAccum, StReady} state_e;
  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] south_q, south_d, east_q, east_d;
  logic                  valid_q, valid_d;

  logic [PW-1:0]         prod_q [MUL_STAGES];
  logic [PW-1:0]         prod_d [MUL_STAGES];
  logic [MUL_STAGES-1:0] mvld_q, mvld_d, mfst_q, mfst_d, mlst_q, mlst_d;

  logic [ACC_WIDTH-1:0]  acc_q, acc_d, acc_out_q, acc_out_d;
  logic                  acc_valid_q, acc_valid_d, done_q, done_d, ovf_q, ovf_d;

  logic                  issue;
  logic [PW-1:0]         n_ext, w_ext, prod, prod_tail;
  logic                  acc_en, acc_first, acc_last;
  logic [ACC_WIDTH-1:0]  acc_base, acc_sum, sat_val;
  logic [ACC_WIDTH:0]    base_ext, prod_ext, sum;
  logic                  sum_ovf;

  assign issue = pe.valid_i & ~pe.drain_mode_i & (pe.first_i | (state_q == StAccum));

  // Low PW bits of the product of the PW-bit extended operands are exact in both modes.
  always_comb begin
    if (SIGNED) begin
      n_ext = {{DATA_WIDTH{pe.north_i[DATA_WIDTH-1]}}, pe.north_i};
      w_ext = {{DATA_WIDTH{pe.west_i[DATA_WIDTH-1]}}, pe.west_i};
    end else begin
      n_ext = {{DATA_WIDTH{1'b0}}, pe.north_i};
      w_ext = {{DATA_WIDTH{1'b0}}, pe.west_i};
    end
    prod = n_ext * w_ext;
  end

  // Multiplier pipeline with valid/first/last tags.
  always_comb begin
    mvld_d = '0;
    mfst_d = '0;
    mlst_d = '0;
    for (int unsigned i = 0; i < MUL_STAGES; i++) begin
      prod_d[i] = '0;
    end
    prod_d[0] = prod;
    mvld_d[0] = issue;
    mfst_d[0] = pe.first_i;
    mlst_d[0] = pe.last_i;
    for (int unsigned i = 1; i < MUL_STAGES; i++) begin
      prod_d[i] = prod_q[i-1];
      mvld_d[i] = mvld_q[i-1];
      mfst_d[i] = mfst_q[i-1];
      mlst_d[i] = mlst_q[i-1];
    end
  end

  // Accumulate stage: add in ACC_WIDTH+1 bits so the guard bit exposes overflow.
  always_comb begin
    acc_en    = mvld_q[MUL_STAGES-1];
    acc_first = mfst_q[MUL_STAGES-1];
    acc_last  = mlst_q[MUL_STAGES-1];
    prod_tail = prod_q[MUL_STAGES-1];
    acc_base  = acc_first ? '0 : acc_q;
    if (SIGNED) begin
      base_ext = {acc_base[ACC_WIDTH-1], acc_base};
      prod_ext = {{XW{prod_tail[PW-1]}}, prod_tail};
    end else begin
      base_ext = {1'b0, acc_base};
      prod_ext = {{XW{1'b0}}, prod_tail};
    end
    sum = base_ext + prod_ext;
    if (SIGNED) begin
      // sum[ACC_WIDTH] is the true sign; clamp towards it.
      sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
      sat_val = {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}};
    end else begin
      sum_ovf = sum[ACC_WIDTH];
      sat_val = '1;
    end
    acc_sum = (sum_ovf && SATURATE) ? sat_val : sum[ACC_WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    acc_out_d   = acc_out_q;
    acc_valid_d = 1'b0;
    south_d     = pe.north_i;
    east_d      = pe.west_i;
    valid_d     = pe.valid_i;

    if (acc_en) begin
      acc_d  = acc_sum;
      ovf_d  = acc_first ? sum_ovf : (ovf_q | sum_ovf);
      done_d = acc_last;
    end

    // A new first issued alongside the read is safe: it reaches acc_q MUL_STAGES+1 cycles later.
    if ((state_q == StReady) && pe.acc_read_i) begin
      acc_out_d   = acc_q;
      acc_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (issue && pe.first_i) state_d = StAccum;
      end
      StAccum: begin
        // A freshly issued first keeps us accumulating even if the previous last lands now.
        if (acc_en && acc_last && !(issue && pe.first_i)) state_d = StReady;
      end
      StReady: begin
        if (issue && pe.first_i) begin
          state_d = StAccum;
        end else if (pe.acc_read_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      south_q     <= '0;
      east_q      <= '0;
      valid_q     <= 1'b0;
      mvld_q      <= '0;
      mfst_q      <= '0;
      mlst_q      <= '0;
      for (int unsigned i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= '0;
      end
      acc_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      south_q     <= south_d;
      east_q      <= east_d;
      valid_q     <= valid_d;
      mvld_q      <= mvld_d;
      mfst_q      <= mfst_d;
      mlst_q      <= mlst_d;
      for (int unsigned i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= prod_d[i];
      end
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      acc_valid_q <= acc_valid_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign pe.south_o     = south_q;
  assign pe.east_o      = east_q;
  assign pe.valid_o     = valid_q;
  assign pe.acc_o       = acc_out_q;
  assign pe.acc_valid_o = acc_valid_q;
  assign pe.done_o      = done_q;
  assign pe.busy_o      = (state_q == StAccum) | (|mvld_q);
  assign pe.overflow_o  = ovf_q;
endmodule

// File: tb/tb_systolic_pe_pipelined.sv
// Scoreboard bench for systolic_pe_pipelined. Four PEs share one stimulus stream, each enabled by
// a mask bit: 0 = signed/40b/saturate, 1 = unsigned/40b, 2 = signed/32b/saturate,
// 3 = signed/32b/wrap. Expected done/acc pulses are queued with their due cycle; a monitor pops
// and compares them when the PE pulses.
module tb_systolic_pe_pipelined;
  localparam int Lat = 3; // MUL_STAGES + 1

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [3:0]  en;
  logic [15:0] north, west;
  logic        valid, first, last, drain, rd;

  systolic_pe_pipelined_if #(.DATA_WIDTH(16), .ACC_WIDTH(40)) bus0 ();
  systolic_pe_pipelined_if #(.DATA_WIDTH(16), .ACC_WIDTH(40)) bus1 ();
  systolic_pe_pipelined_if #(.DATA_WIDTH(16), .ACC_WIDTH(32)) bus2 ();
  systolic_pe_pipelined_if #(.DATA_WIDTH(16), .ACC_WIDTH(32)) bus3 ();

  assign bus0.north_i = north;  assign bus0.west_i = west;  assign bus0.valid_i = valid & en[0];
  assign bus0.first_i = first;  assign bus0.last_i = last;  assign bus0.drain_mode_i = drain;
  assign bus0.acc_read_i = rd & en[0];
  assign bus1.north_i = north;  assign bus1.west_i = west;  assign bus1.valid_i = valid & en[1];
  assign bus1.first_i = first;  assign bus1.last_i = last;  assign bus1.drain_mode_i = drain;
  assign bus1.acc_read_i = rd & en[1];
  assign bus2.north_i = north;  assign bus2.west_i = west;  assign bus2.valid_i = valid & en[2];
  assign bus2.first_i = first;  assign bus2.last_i = last;  assign bus2.drain_mode_i = drain;
  assign bus2.acc_read_i = rd & en[2];
  assign bus3.north_i = north;  assign bus3.west_i = west;  assign bus3.valid_i = valid & en[3];
  assign bus3.first_i = first;  assign bus3.last_i = last;  assign bus3.drain_mode_i = drain;
  assign bus3.acc_read_i = rd & en[3];

  systolic_pe_pipelined #(.DATA_WIDTH(16), .ACC_WIDTH(40), .MUL_STAGES(2), .SIGNED(1'b1),
    .SATURATE(1'b1)) u_dut0 (.clk_i(clk), .rstn_i(rstn), .pe(bus0));
  systolic_pe_pipelined #(.DATA_WIDTH(16), .ACC_WIDTH(40), .MUL_STAGES(2), .SIGNED(1'b0),
    .SATURATE(1'b1)) u_dut1 (.clk_i(clk), .rstn_i(rstn), .pe(bus1));
  systolic_pe_pipelined #(.DATA_WIDTH(16), .ACC_WIDTH(32), .MUL_STAGES(2), .SIGNED(1'b1),
    .SATURATE(1'b1)) u_dut2 (.clk_i(clk), .rstn_i(rstn), .pe(bus2));
  systolic_pe_pipelined #(.DATA_WIDTH(16), .ACC_WIDTH(32), .MUL_STAGES(2), .SIGNED(1'b1),
    .SATURATE(1'b0)) u_dut3 (.clk_i(clk), .rstn_i(rstn), .pe(bus3));

  logic [39:0] acc_val [4];
  logic        acc_v [4], done_v [4], busy_v [4], ovf_v [4];
  assign acc_val[0] = bus0.acc_o;
  assign acc_val[1] = bus1.acc_o;
  assign acc_val[2] = {8'h00, bus2.acc_o};
  assign acc_val[3] = {8'h00, bus3.acc_o};
  assign acc_v[0] = bus0.acc_valid_o; assign acc_v[1] = bus1.acc_valid_o;
  assign acc_v[2] = bus2.acc_valid_o; assign acc_v[3] = bus3.acc_valid_o;
  assign done_v[0] = bus0.done_o; assign done_v[1] = bus1.done_o;
  assign done_v[2] = bus2.done_o; assign done_v[3] = bus3.done_o;
  assign busy_v[0] = bus0.busy_o; assign busy_v[1] = bus1.busy_o;
  assign busy_v[2] = bus2.busy_o; assign busy_v[3] = bus3.busy_o;
  assign ovf_v[0] = bus0.overflow_o; assign ovf_v[1] = bus1.overflow_o;
  assign ovf_v[2] = bus2.overflow_o; assign ovf_v[3] = bus3.overflow_o;

  // kind 0: done pulse, kind 1: acc_valid pulse with value
  typedef struct {
    int          kind;
    int          dut;
    int          cyc;
    logic [39:0] acc;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input int d, input int at, input logic [39:0] a,
                      input logic o);
    exp_t e;
    e.kind = k; e.dut = d; e.cyc = at; e.acc = a; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic monitor();
    logic [15:0] pn, pw;
    logic        pv, have, pulse;
    int          idx;
    have = 1'b0;
    pn = '0; pw = '0; pv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        have = 1'b0;
      end else begin
        if (have) begin
          check("pass south_o", 40'(bus0.south_o), 40'(pn));
          check("pass east_o", 40'(bus0.east_o), 40'(pw));
          check("pass valid_o", 40'(bus0.valid_o), 40'(pv));
        end
        pn = north; pw = west; pv = valid & en[0]; have = 1'b1;
        for (int d = 0; d < 4; d++) begin
          for (int k = 0; k < 2; k++) begin
            pulse = (k == 1) ? acc_v[d] : done_v[d];
            if (pulse) begin
              idx = -1;
              foreach (sb[j]) begin
                if (idx < 0 && sb[j].kind == k && sb[j].dut == d && sb[j].cyc == cyc) idx = j;
              end
              if (idx < 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected %s dut%0d: got pulse at cycle %0d, expected none",
                         (k == 1) ? "acc_valid_o" : "done_o", d, cyc);
              end else begin
                if (k == 1) begin
                  check($sformatf("acc_o dut%0d", d), acc_val[d], sb[idx].acc);
                  check($sformatf("overflow_o dut%0d", d), 40'(ovf_v[d]), 40'(sb[idx].ovf));
                end else begin
                  checks++;
                end
                sb.delete(idx);
              end
            end
          end
        end
        for (int j = sb.size() - 1; j >= 0; j--) begin
          if (sb[j].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed %s dut%0d: got no pulse, expected at cycle %0d",
                     (sb[j].kind == 1) ? "acc_valid_o" : "done_o", sb[j].dut, sb[j].cyc);
            sb.delete(j);
          end
        end
      end
      cyc++;
    end
  endtask

  task automatic drive(input logic [3:0] m, input logic [15:0] n, input logic [15:0] w,
                       input logic v, input logic f, input logic l, input logic dr,
                       input logic r);
    @(posedge clk);
    #2;
    en = m; north = n; west = w; valid = v; first = f; last = l; drain = dr; rd = r;
  endtask

  task automatic mac(input logic [3:0] m, input logic [15:0] n, input logic [15:0] w,
                     input logic f, input logic l);
    drive(m, n, w, 1'b1, f, l, 1'b0, 1'b0);
    if (l) begin
      for (int d = 0; d < 4; d++) if (m[d]) push(0, d, cyc + Lat, '0, 1'b0);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) drive(en, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic read(input logic [3:0] m);
    drive(m, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Call immediately after the read beat: result appears one cycle later.
  task automatic exp_acc(input int d, input logic [39:0] a, input logic o);
    push(1, d, cyc + 1, a, o);
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s acc_o dut%0d", tag, d), acc_val[d], 40'h0);
      check($sformatf("%s flags dut%0d", tag, d),
            40'({acc_v[d], done_v[d], busy_v[d], ovf_v[d]}), 40'h0);
    end
    check({tag, " passthrough"}, 40'({bus0.south_o, bus0.east_o, bus0.valid_o}), 40'h0);
  endtask

  initial begin
    rstn = 1'b0; en = '0; north = '0; west = '0;
    valid = 1'b0; first = 1'b0; last = 1'b0; drain = 1'b0; rd = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #2;
    check_reset("reset");
    @(posedge clk);
    #2;
    rstn = 1'b1;

    // Four back-to-back beats: 2+12+30+56 = 100 (signed and unsigned PEs)
    mac(4'b0011, 16'd1, 16'd2, 1'b1, 1'b0);
    mac(4'b0011, 16'd3, 16'd4, 1'b0, 1'b0);
    mac(4'b0011, 16'd5, 16'd6, 1'b0, 1'b0);
    mac(4'b0011, 16'd7, 16'd8, 1'b0, 1'b1);
    idle(1);
    check("busy_o accumulating", 40'(busy_v[0]), 40'h1);
    idle(2);
    read(4'b0011);
    exp_acc(0, 40'd100, 1'b0);
    exp_acc(1, 40'd100, 1'b0);
    idle(2);
    check("busy_o idle", 40'(busy_v[0]), 40'h0);
    check("acc_o holds", acc_val[0], 40'd100);

    // Signed: (-3)*5 + 2*(-4) = -23
    mac(4'b0001, 16'hFFFD, 16'd5, 1'b1, 1'b0);
    mac(4'b0001, 16'd2, 16'hFFFC, 1'b0, 1'b1);
    idle(3);
    read(4'b0001);
    exp_acc(0, 40'hFF_FFFF_FFE9, 1'b0);
    idle(1);

    // Single-term first+last: 0xFFFF*0xFFFF is 1 signed, 0xFFFE0001 unsigned
    mac(4'b0011, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    idle(3);
    read(4'b0011);
    exp_acc(0, 40'h00_0000_0001, 1'b0);
    exp_acc(1, 40'h00_FFFE_0001, 1'b0);
    idle(1);

    // 32-bit accumulators: three 0x3FFF0001 terms overflow on the third
    mac(4'b1100, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
    mac(4'b1100, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    mac(4'b1100, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
    idle(3);
    read(4'b1100);
    exp_acc(2, 40'h00_7FFF_FFFF, 1'b1);
    exp_acc(3, 40'h00_BFFD_0003, 1'b1);
    idle(1);
    // A new first clears the sticky overflow
    mac(4'b1100, 16'd1, 16'd1, 1'b1, 1'b1);
    idle(3);
    read(4'b1100);
    exp_acc(2, 40'd1, 1'b0);
    exp_acc(3, 40'd1, 1'b0);
    idle(1);

    // Drain beats interleaved (one with first set), read ignored in ACCUM: 6+20+1 = 27
    mac(4'b0001, 16'd2, 16'd3, 1'b1, 1'b0);
    drive(4'b0001, 16'd100, 16'd100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(4'b0001, 16'd4, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(4'b0001, 16'd9, 16'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    mac(4'b0001, 16'd1, 16'd1, 1'b0, 1'b1);
    idle(3);
    // Read together with a new first: old 27 returned, new sum 100+2 = 102
    drive(4'b0001, 16'd10, 16'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_acc(0, 40'd27, 1'b0);
    mac(4'b0001, 16'd1, 16'd2, 1'b0, 1'b1);
    idle(3);
    read(4'b0001);
    exp_acc(0, 40'd102, 1'b0);
    idle(1);

    // Restart inside ACCUM: 25+1 discarded, result 4+9 = 13
    mac(4'b0001, 16'd5, 16'd5, 1'b1, 1'b0);
    mac(4'b0001, 16'd1, 16'd1, 1'b0, 1'b0);
    mac(4'b0001, 16'd2, 16'd2, 1'b1, 1'b0);
    mac(4'b0001, 16'd3, 16'd3, 1'b0, 1'b1);
    idle(3);
    read(4'b0001);
    exp_acc(0, 40'd13, 1'b0);
    idle(2);

    // Reset with two beats in flight, then a clean single-term sequence: 3*(-2) = -6
    mac(4'b0001, 16'd7, 16'd7, 1'b1, 1'b0);
    mac(4'b0001, 16'd7, 16'd7, 1'b0, 1'b0);
    check("busy_o in flight", 40'(busy_v[0]), 40'h1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    valid = 1'b0; first = 1'b0; last = 1'b0; north = '0; west = '0;
    #1;
    check_reset("mid reset");
    idle(2);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    idle(1);
    mac(4'b0001, 16'd3, 16'hFFFE, 1'b1, 1'b1);
    idle(3);
    read(4'b0001);
    exp_acc(0, 40'hFF_FFFF_FFFA, 1'b0);
    idle(4);

    foreach (sb[j]) begin
      checks++;
      errors++;
      $display("FAIL pending %s dut%0d: got no pulse, expected at cycle %0d",
               (sb[j].kind == 1) ? "acc_valid_o" : "done_o", sb[j].dut, sb[j].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
